mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm_pkg.sv | 56 +++++
 rtl/mc_opcode_class.sv | 40 ++++
 rtl/mc_control_fsm.sv | 176 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared constants for the multicycle control unit: opcodes, state encoding,
// datapath select codes and the bundled control-word type.
package mc_control_fsm_pkg;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IF, ST_ID, ST_EX, ST_BR, ST_MEM, ST_WB, ST_HALT
  } state_t;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       aluout_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic [1:0] wb_sel;
    logic       is_ecall;
    logic       instr_done;
    logic       halted;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier; exactly one output is high for any opcode.
module mc_opcode_class
  import mc_control_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       arith,
  output logic       arith_imm,
  output logic       load,
  output logic       store,
  output logic       branch,
  output logic       jal,
  output logic       jalr,
  output logic       ecall,
  output logic       illegal
);

  always_comb begin
    arith     = 1'b0;
    arith_imm = 1'b0;
    load      = 1'b0;
    store     = 1'b0;
    branch    = 1'b0;
    jal       = 1'b0;
    jalr      = 1'b0;
    ecall     = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_ARITH:     arith     = 1'b1;
      OP_ARITH_IMM: arith_imm = 1'b1;
      OP_LOAD:      load      = 1'b1;
      OP_STORE:     store     = 1'b1;
      OP_BRANCH:    branch    = 1'b1;
      OP_JAL:       jal       = 1'b1;
      OP_JALR:      jalr      = 1'b1;
      OP_ECALL:     ecall     = 1'b1;
      default:      illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: state register plus a decode of state, opcode and
// the memory/branch handshakes into the datapath control word.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       aluout_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic [1:0] wb_sel,
  output logic       is_ecall,
  output logic       instr_done,
  output logic       halted,
  output logic       illegal
);

  state_t state, next_state;
  logic   halt_illegal;
  ctrl_t  ctrl, ctrl_out;
  logic   c_arith, c_arith_imm, c_load, c_store, c_branch;
  logic   c_jal, c_jalr, c_ecall, c_illegal;

  mc_opcode_class u_opcode_class (
    .opcode    (opcode),
    .arith     (c_arith),
    .arith_imm (c_arith_imm),
    .load      (c_load),
    .store     (c_store),
    .branch    (c_branch),
    .jal       (c_jal),
    .jalr      (c_jalr),
    .ecall     (c_ecall),
    .illegal   (c_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IF;
      halt_illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_ID && c_illegal)
        halt_illegal <= 1'b1;
    end
  end

  always_comb begin
    ctrl       = '0;
    next_state = state;
    case (state)
      ST_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PC_SRC_ALU;
          next_state     = ST_ID;
        end
      end
      ST_ID: begin
        // Branch/JAL target is precomputed here into ALUOut.
        ctrl.alu_src_a    = SRC_A_OLDPC;
        ctrl.alu_src_b    = SRC_B_IMM;
        ctrl.alu_op       = ALU_ADD;
        ctrl.aluout_write = 1'b1;
        if (c_ecall) begin
          ctrl.is_ecall = 1'b1;
          next_state    = halt_req ? ST_HALT : ST_IF;
        end else if (c_branch) begin
          next_state = ST_BR;
        end else if (c_illegal) begin
          next_state = ST_HALT;
        end else begin
          next_state = ST_EX;
        end
      end
      ST_EX: begin
        if (c_arith || c_arith_imm) begin
          ctrl.alu_src_a    = SRC_A_RS1;
          ctrl.alu_src_b    = c_arith ? SRC_B_RS2 : SRC_B_IMM;
          ctrl.alu_op       = ALU_FUNCT;
          ctrl.aluout_write = 1'b1;
          next_state        = ST_WB;
        end else if (c_load || c_store) begin
          ctrl.alu_src_a    = SRC_A_RS1;
          ctrl.alu_src_b    = SRC_B_IMM;
          ctrl.alu_op       = ALU_ADD;
          ctrl.aluout_write = 1'b1;
          next_state        = ST_MEM;
        end else if (c_jal) begin
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel    = WB_PC;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PC_SRC_ALUOUT;
          next_state     = ST_IF;
        end else if (c_jalr) begin
          ctrl.alu_src_a = SRC_A_RS1;
          ctrl.alu_src_b = SRC_B_IMM;
          ctrl.alu_op    = ALU_ADD;
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel    = WB_PC;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PC_SRC_ALU;
          next_state     = ST_IF;
        end else begin
          next_state = ST_IF;
        end
      end
      ST_BR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_BRANCH;
        ctrl.pc_write  = alu_bcond;
        ctrl.pc_source = PC_SRC_ALUOUT;
        next_state     = ST_IF;
      end
      ST_MEM: begin
        // Request lines depend only on state and the held opcode, so they
        // stay constant for the whole wait.
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = c_load;
        ctrl.mem_write = c_store;
        if (mem_ready)
          next_state = c_load ? ST_WB : ST_IF;
      end
      ST_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = c_load ? WB_MDR : WB_ALUOUT;
        next_state     = ST_IF;
      end
      ST_HALT: begin
        ctrl.halted  = 1'b1;
        ctrl.illegal = halt_illegal;
      end
      default: next_state = ST_IF;
    endcase
    ctrl.instr_done = (state != ST_IF) && (next_state == ST_IF);
  end

  // Gating on reset_n itself drops any request in the very cycle reset asserts.
  assign ctrl_out = reset_n ? ctrl : '0;

  assign pc_write     = ctrl_out.pc_write;
  assign ir_write     = ctrl_out.ir_write;
  assign aluout_write = ctrl_out.aluout_write;
  assign mem_read     = ctrl_out.mem_read;
  assign mem_write    = ctrl_out.mem_write;
  assign i_or_d       = ctrl_out.i_or_d;
  assign reg_write    = ctrl_out.reg_write;
  assign alu_src_a    = ctrl_out.alu_src_a;
  assign alu_src_b    = ctrl_out.alu_src_b;
  assign alu_op       = ctrl_out.alu_op;
  assign pc_source    = ctrl_out.pc_source;
  assign wb_sel       = ctrl_out.wb_sel;
  assign is_ecall     = ctrl_out.is_ecall;
  assign instr_done   = ctrl_out.instr_done;
  assign halted       = ctrl_out.halted;
  assign illegal      = ctrl_out.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction expectations are queued at issue
// time and compared by a monitor that summarises each instruction's outputs.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic       alu_bcond, mem_ready, halt_req;
  logic       pc_write, ir_write, aluout_write, mem_read, mem_write, i_or_d, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
  logic       pc_source, is_ecall, instr_done, halted, illegal;
  logic [19:0] all_out;

  mc_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_bcond(alu_bcond),
    .mem_ready(mem_ready), .halt_req(halt_req), .pc_write(pc_write),
    .ir_write(ir_write), .aluout_write(aluout_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .wb_sel(wb_sel), .is_ecall(is_ecall),
    .instr_done(instr_done), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign all_out = {pc_write, ir_write, aluout_write, mem_read, mem_write, i_or_d,
                    reg_write, alu_src_a, alu_src_b, alu_op, pc_source, wb_sel,
                    is_ecall, instr_done, halted, illegal};

  typedef enum int {K_ARITH, K_IMM, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR,
                    K_ECALL, K_ILLEGAL} kind_t;

  typedef struct {
    int op;
    int cycles;
    int mem_rd;
    int mem_wr;
    int iord;
    int irw;
    int pcw;
    int pcsrc;
    int regw;
    int wbsel;
    int ecall;
    int done;
    int halt;
    int ill;
    int opmask;
    int amask;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  int o_cycles, o_mrd, o_mwr, o_iord, o_irw, o_pcw, o_pcsrc, o_regw, o_wbsel;
  int o_ecall, o_done, o_opmask, o_amask;
  int halt_cycles, halt_bad;
  bit in_halt;

  logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011};

  task automatic checkOutput(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic kind_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: return K_ARITH;
      7'b0010011: return K_IMM;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BRANCH;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b1110011: return K_ECALL;
      default:    return K_ILLEGAL;
    endcase
  endfunction

  // Instruction-level model: phase lengths and per-instruction event counts.
  function automatic exp_t predict(input logic [6:0] op, input int fw, input int mw,
                                   input bit bc, input bit hr);
    exp_t e;
    kind_t k;
    bit taken, stops;
    k     = classify(op);
    taken = (k == K_BRANCH) && bc;
    stops = (k == K_ILLEGAL) || (k == K_ECALL && hr);
    e.op     = int'(op);
    e.cycles = fw + 2;
    case (k)
      K_ARITH, K_IMM:          e.cycles += 2;
      K_LOAD:                  e.cycles += mw + 3;
      K_STORE:                 e.cycles += mw + 2;
      K_BRANCH, K_JAL, K_JALR: e.cycles += 1;
      default:                 e.cycles += 0;
    endcase
    e.mem_rd = fw + 1 + ((k == K_LOAD) ? mw + 1 : 0);
    e.mem_wr = (k == K_STORE) ? mw + 1 : 0;
    e.iord   = (k == K_LOAD || k == K_STORE) ? mw + 1 : 0;
    e.irw    = 1;
    e.pcw    = 1 + ((k == K_JAL || k == K_JALR || taken) ? 1 : 0);
    e.pcsrc  = (k == K_JAL || taken) ? 1 : 0;
    e.regw   = (k == K_ARITH || k == K_IMM || k == K_LOAD || k == K_JAL || k == K_JALR) ? 1 : 0;
    e.wbsel  = (k == K_LOAD) ? 1 : ((k == K_JAL || k == K_JALR) ? 2 : 0);
    e.ecall  = (k == K_ECALL) ? 1 : 0;
    e.done   = stops ? 0 : 1;
    e.halt   = stops ? 1 : 0;
    e.ill    = (k == K_ILLEGAL) ? 1 : 0;
    e.opmask = 1 | ((k == K_ARITH || k == K_IMM) ? 4 : 0) | ((k == K_BRANCH) ? 2 : 0);
    e.amask  = 3 | ((k == K_JAL || k == K_ECALL || k == K_ILLEGAL) ? 0 : 4);
    return e;
  endfunction

  task automatic clearObs();
    o_cycles = 0; o_mrd = 0; o_mwr = 0; o_iord = 0; o_irw = 0; o_pcw = 0;
    o_pcsrc = 0; o_regw = 0; o_wbsel = 0; o_ecall = 0; o_done = 0;
    o_opmask = 0; o_amask = 0;
  endtask

  task automatic compareRecord(input int saw_halt, input int saw_ill);
    exp_t e;
    checkOutput("scoreboard_has_entry", int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput($sformatf("cycles op=%b", e.op[6:0]), o_cycles, e.cycles);
      checkOutput("mem_read_cycles", o_mrd, e.mem_rd);
      checkOutput("mem_write_cycles", o_mwr, e.mem_wr);
      checkOutput("i_or_d_cycles", o_iord, e.iord);
      checkOutput("ir_write_cycles", o_irw, e.irw);
      checkOutput("pc_write_cycles", o_pcw, e.pcw);
      checkOutput("pc_source_on_write", o_pcsrc, e.pcsrc);
      checkOutput("reg_write_cycles", o_regw, e.regw);
      checkOutput("wb_sel", o_wbsel, e.wbsel);
      checkOutput("is_ecall_cycles", o_ecall, e.ecall);
      checkOutput("instr_done_cycles", o_done, e.done);
      checkOutput("halted", saw_halt, e.halt);
      checkOutput("illegal", saw_ill, e.ill);
      checkOutput("alu_op_set", o_opmask, e.opmask);
      checkOutput("alu_src_a_set", o_amask, e.amask);
    end
  endtask

  // Monitor: folds each cycle into the running instruction summary.
  always @(negedge clk) begin
    if (!reset_n) begin
      checkOutput("reset_outputs_zero", int'(all_out), 0);
      clearObs();
      in_halt     = 1'b0;
      halt_cycles = 0;
      halt_bad    = 0;
    end else if (halted) begin
      halt_cycles++;
      if (all_out[19:2] != '0) halt_bad++;
      if (!in_halt) begin
        in_halt = 1'b1;
        compareRecord(1, int'(illegal));
      end
    end else begin
      o_cycles++;
      o_mrd  += int'(mem_read);
      o_mwr  += int'(mem_write);
      o_iord += int'(i_or_d);
      o_irw  += int'(ir_write);
      o_pcw  += int'(pc_write);
      o_ecall += int'(is_ecall);
      o_done += int'(instr_done);
      if (pc_write && pc_source) o_pcsrc = 1;
      if (reg_write) begin
        o_regw++;
        o_wbsel = int'(wb_sel);
      end
      o_opmask |= (1 << alu_op);
      o_amask  |= (1 << alu_src_a);
      if (instr_done) begin
        compareRecord(0, 0);
        clearObs();
      end
    end
  end

  task automatic driveCycle(input bit mr);
    mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic driveIgnored();
    driveCycle(1'($urandom_range(0, 1)));
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    opcode    = 7'($urandom);
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Issues one instruction; mem_ready is randomised wherever it must be ignored.
  task automatic applyStimulus(input logic [6:0] op, input int fw, input int mw,
                               input bit bc, input bit hr, output bit stops);
    exp_t  e;
    kind_t k;
    e = predict(op, fw, mw, bc, hr);
    k = classify(op);
    sb.push_back(e);
    stops     = (e.halt != 0);
    opcode    = op;
    alu_bcond = bc;
    halt_req  = hr;
    for (int i = 0; i <= fw; i++) driveCycle(i == fw);
    driveIgnored();
    case (k)
      K_ARITH, K_IMM: begin driveIgnored(); driveIgnored(); end
      K_LOAD, K_STORE: begin
        driveIgnored();
        for (int i = 0; i <= mw; i++) driveCycle(i == mw);
        if (k == K_LOAD) driveIgnored();
      end
      K_BRANCH, K_JAL, K_JALR: driveIgnored();
      default: ;
    endcase
  endtask

  task automatic haltPhase();
    for (int i = 0; i < 20; i++) begin
      opcode    = 7'($urandom);
      alu_bcond = 1'($urandom_range(0, 1));
      halt_req  = 1'($urandom_range(0, 1));
      driveIgnored();
    end
    checkOutput("halt_cycles", halt_cycles, 20);
    checkOutput("halt_outputs_quiet", halt_bad, 0);
  endtask

  task automatic resetDuringStore();
    opcode    = 7'b0100011;
    alu_bcond = 1'b0;
    halt_req  = 1'b0;
    driveCycle(1'b1);
    driveCycle(1'b0);
    driveCycle(1'b0);
    mem_ready = 1'b0;
    #2;
    checkOutput("store_wait_mem_write", int'(mem_write), 1);
    checkOutput("store_wait_i_or_d", int'(i_or_d), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_mem_write", int'(mem_write), 0);
    checkOutput("abort_all_zero", int'(all_out), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    #2;
    checkOutput("post_reset_mem_read", int'(mem_read), 1);
    checkOutput("post_reset_i_or_d", int'(i_or_d), 0);
    checkOutput("post_reset_reg_write", int'(reg_write), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit         stops;
    logic [6:0] op;
    reset_n   = 1'b0;
    opcode    = '0;
    alu_bcond = 1'b0;
    mem_ready = 1'b0;
    halt_req  = 1'b0;
    doReset();

    applyStimulus(7'b0110011, 0, 0, 1'b0, 1'b0, stops);
    applyStimulus(7'b0000011, 0, 3, 1'b0, 1'b0, stops);
    applyStimulus(7'b1100011, 0, 0, 1'b1, 1'b0, stops);
    applyStimulus(7'b1100011, 0, 0, 1'b0, 1'b0, stops);
    applyStimulus(7'b1101111, 1, 0, 1'b0, 1'b1, stops);
    applyStimulus(7'b1100111, 0, 0, 1'b1, 1'b0, stops);
    applyStimulus(7'b0100011, 2, 2, 1'b0, 1'b0, stops);
    applyStimulus(7'b0010011, 0, 0, 1'b0, 1'b1, stops);
    applyStimulus(7'b1110011, 0, 0, 1'b0, 1'b0, stops);
    applyStimulus(7'b1110011, 0, 0, 1'b0, 1'b1, stops);
    haltPhase();
    doReset();
    applyStimulus(7'b0000000, 0, 0, 1'b0, 1'b0, stops);
    haltPhase();
    doReset();
    resetDuringStore();
    doReset();

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 99) < 4) begin
        do op = 7'($urandom); while (classify(op) != K_ILLEGAL);
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      applyStimulus(op, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0, stops);
      if (stops) begin
        haltPhase();
        doReset();
      end
    end

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
